alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Supports the same eight-operation encoding.
- Adds registered Carry/OverFlow/Zero/Negative flags.
- Adds a multi-cycle iterative shift-add multiplier in place of a combinational multiply.
- Sits between decode/register-read and writeback in the multi-cycle core.
- Uses valid/ready on both sides so the control FSM can stall on multiplies.

Parameters:
- WIDTH, 32: operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH)+1: multiply iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  operand/opcode presented.
- in_ready  output  1  block can accept an operation.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUControl  input  3  opcode:
  - 000 add, 001 sub, 010 and, 011 or
  - 101 xor, 100 nand, 110 nor, 111 mul
- out_valid  output  1  Result/flags valid.
- out_ready  input  1  consumer accepts result.
- Result  output  WIDTH  registered result.
- Carry  output  1  carry-out (add/sub only).
- OverFlow  output  1  signed overflow (add/sub only).
- Zero  output  1  Result == 0.
- Negative  output  1  Result[WIDTH-1].
- busy  output  1  multiply in progress.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - Result, all flags, out_valid and busy = 0; in_ready = 1 in the cycle after reset.
  - Reset mid-multiply aborts the operation; no result is produced.
- States: IDLE, MUL, DONE.
- in_ready is 1 only in IDLE. An operation is accepted when in_valid & in_ready at a clk edge; A, B and ALUControl are captured then.
- IDLE, non-mul accept:
  - Compute combinationally and register Result/flags; go to DONE.
  - out_valid=1 the next cycle (latency 1).
- IDLE, mul accept:
  - Load multiplicand=A, multiplier=B, acc=0, cnt=0; go to MUL; busy=1.
- MUL, each cycle:
  - If multiplier[0], acc = acc + multiplicand (mod 2^WIDTH).
  - multiplicand <<= 1; multiplier >>= 1; cnt++.
  - When cnt reaches WIDTH-1 (WIDTH iterations total): Result=acc (final add included), go to DONE, busy=0.
  - Total latency: WIDTH+1 cycles from accept to out_valid. Early termination is not allowed; latency is fixed.
- DONE:
  - out_valid=1; Result and flags hold stable while out_ready=0.
  - On out_ready=1: go to IDLE, out_valid=0 the next cycle.
  - No back-to-back accept in the same cycle: in_ready stays 0 in DONE.
- Arithmetic:
  - Sum = A+B for op[0]=0, A+~B+1 for op[0]=1, computed at WIDTH+1 bits.
  - Carry = bit WIDTH of the sum (sub: 1 = no borrow).
  - OverFlow = (Sum[MSB]^A[MSB]) & ~(op[0]^B[MSB]^A[MSB]).
  - Carry and OverFlow are 0 for all logical ops and mul.
  - Mul keeps the low WIDTH bits of the product (signed/unsigned identical).
- Zero and Negative are derived from the final Result for every op.
- in_valid while not in IDLE is ignored (not queued); the upstream must hold it.

Test Plan:
- Reset then add, WIDTH=32: A=0x7FFFFFFF, B=1, op 000.
  - out_valid one cycle after accept.
  - Result=0x80000000, OverFlow=1, Negative=1, Carry=0, Zero=0.
- Sub: A=5, B=5, op 001.
  - Result=0, Zero=1, Carry=1, OverFlow=0.
  - Repeat with A=3, B=5 -> Result=0xFFFFFFFE, Carry=0, Negative=1.
- Logic ops with A=0xF0F0F0F0, B=0xFF00FF00:
  - and -> 0xF000F000
  - or -> 0xFFF0FFF0
  - xor -> 0x0FF00FF0
  - nand -> 0x0FFF0FFF
  - nor -> 0x000F000F
  - Carry and OverFlow are 0 for all five.
- Mul: A=0x00012345, B=0x00010000, op 111.
  - busy=1 and in_ready=0 for 32 cycles.
  - out_valid at accept+33; Result=0x23450000.
  - Mul with A=0xFFFFFFFF, B=0xFFFFFFFF -> Result=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid.
  - Result and flags are stable throughout; in_ready=0; in_valid pulses are ignored.
  - out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset mid-mul: assert rst=0 at cycle 10 of a multiply.
  - Next cycle: out_valid=0, busy=0, Result=0.
  - After release, a new add completes correctly.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered flags and an iterative shift-add
// multiplier. Accepts one operation in IDLE. Logic and add/sub results appear
// one cycle later. A multiply takes WIDTH iterations. The result is held in
// DONE until the consumer takes it.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             OverFlow,
  output logic             Zero,
  output logic             Negative,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [2:0]       OP_ADD  = 3'b000;
  localparam logic [2:0]       OP_SUB  = 3'b001;
  localparam logic [2:0]       OP_AND  = 3'b010;
  localparam logic [2:0]       OP_OR   = 3'b011;
  localparam logic [2:0]       OP_NAND = 3'b100;
  localparam logic [2:0]       OP_XOR  = 3'b101;
  localparam logic [2:0]       OP_NOR  = 3'b110;
  localparam logic [2:0]       OP_MUL  = 3'b111;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, ovf_q, zero_q, neg_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   sum_d;
  logic [WIDTH-1:0] b_eff_d;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_carry_d, alu_ovf_d;
  logic [WIDTH-1:0] acc_d;

  // Single-cycle ALU on the presented operands and the next multiply partial sum.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    alu_res_d   = '0;
    alu_carry_d = 1'b0;
    alu_ovf_d   = 1'b0;
    b_eff_d     = ALUControl[0] ? ~B : B;
    sum_d       = {1'b0, A} + {1'b0, b_eff_d} + {{WIDTH{1'b0}}, ALUControl[0]};
    unique case (ALUControl)
      OP_ADD, OP_SUB: begin
        alu_res_d   = sum_d[WIDTH-1:0];
        alu_carry_d = sum_d[WIDTH];
        alu_ovf_d   = (sum_d[WIDTH-1] ^ A[WIDTH-1]) &
                      ~(ALUControl[0] ^ B[WIDTH-1] ^ A[WIDTH-1]);
      end
      OP_AND:  alu_res_d = A & B;
      OP_OR:   alu_res_d = A | B;
      OP_XOR:  alu_res_d = A ^ B;
      OP_NAND: alu_res_d = ~(A & B);
      OP_NOR:  alu_res_d = ~(A | B);
      OP_MUL:  alu_res_d = '0;
      default: alu_res_d = '0;
    endcase
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  // Control FSM with the registered result, flags and multiplier datapath.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      // NOTE: the multiplier working registers are not reset; they are always
      // loaded on a multiply accept before they are read.
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (ALUControl == OP_MUL) begin
              mcand_q  <= A;
              mplier_q <= B;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= MUL;
            end else begin
              result_q <= alu_res_d;
              carry_q  <= alu_carry_d;
              ovf_q    <= alu_ovf_d;
              zero_q   <= (alu_res_d == '0);
              neg_q    <= alu_res_d[WIDTH-1];
              state_q  <= DONE;
            end
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_W'(1);
          // Fixed latency: always run all WIDTH iterations.
          if (cnt_q == LAST_IT) begin
            result_q <= acc_d;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= (acc_d == '0);
            neg_q    <= acc_d[WIDTH-1];
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Carry     = carry_q;
  assign OverFlow  = ovf_q;
  assign Zero      = zero_q;
  assign Negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=32). Flags are compared as
// {Carry, OverFlow, Zero, Negative}.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic [2:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        Carry, OverFlow, Zero, Negative, busy;

  int checks   = 0;
  int failures = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Carry(Carry),
    .OverFlow(OverFlow), .Zero(Zero), .Negative(Negative), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, Carry, OverFlow, Zero, Negative};
  endfunction

  // Present one operation and hold it until accepted (bounded wait).
  task automatic accept(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    A = a; B = b; ALUControl = op; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Single-cycle op: out_valid must be up right after the accept edge.
  task automatic alu_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags);
    accept(tag, a, b, op);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_result"}, Result, exp_res);
    check({tag, "_flags"}, flags(), {28'd0, exp_flags});
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_rel_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_rel_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  // Multiply: count busy cycles and edges until out_valid, then check result.
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
    int cyc = 0;
    int busy_cnt = 0;
    accept(tag, a, b, 3'b111);
    while (!out_valid && cyc < 100) begin
      if (busy && !in_ready) busy_cnt++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, 32);
    check({tag, "_busy_cycles"}, busy_cnt, 32);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, Result, exp_res);
    check({tag, "_flags"}, flags(), {28'd0, 1'b0, 1'b0, exp_res == 32'd0, exp_res[31]});
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; ALUControl = '0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_flags", flags(), 32'd0);
    rst = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Add with signed overflow.
    alu_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 3'b000, 32'h8000_0000, 4'b0101);
    release_out("add_ovf");

    // Subtract: equal operands, then borrow.
    alu_op("sub_eq", 32'd5, 32'd5, 3'b001, 32'd0, 4'b1010);
    release_out("sub_eq");
    alu_op("sub_neg", 32'd3, 32'd5, 3'b001, 32'hFFFF_FFFE, 4'b0001);

    // Backpressure on the sub result: hold, with ignored in_valid pulses.
    for (int i = 0; i < 5; i++) begin
      A = 32'd1; B = 32'd1; ALUControl = 3'b000;
      in_valid = (i % 2 == 0);
      tick();
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_result", Result, 32'hFFFF_FFFE);
      check("bp_flags", flags(), 32'h1);
    end
    in_valid = 1'b0;
    release_out("bp");
    check("bp_result_after", Result, 32'hFFFF_FFFE);

    // Logic ops.
    alu_op("and", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b010, 32'hF000_F000, 4'b0001);
    release_out("and");
    alu_op("or", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011, 32'hFFF0_FFF0, 4'b0001);
    release_out("or");
    alu_op("xor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b101, 32'h0FF0_0FF0, 4'b0000);
    release_out("xor");
    alu_op("nand", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100, 32'h0FFF_0FFF, 4'b0000);
    release_out("nand");
    alu_op("nor", 32'hF0F0_F0F0, 32'hFF00_FF00, 3'b110, 32'h000F_000F, 4'b0000);
    release_out("nor");

    // Multiplies.
    mul_op("mul1", 32'h0001_2345, 32'h0001_0000, 32'h2345_0000);
    release_out("mul1");
    mul_op("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    release_out("mul_ff");

    // Reset in the middle of a multiply.
    accept("mul_abort", 32'h1234_5678, 32'h9ABC_DEF0, 3'b111);
    for (int i = 0; i < 9; i++) tick();
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    tick();
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", Result, 32'd0);
    rst = 1'b1;
    tick();
    alu_op("post_rst_add", 32'd2, 32'd3, 3'b000, 32'd5, 4'b0000);
    release_out("post_rst_add");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
